// File: rtl/wbc_dec.sv
// Wishbone address decoder with bus-timeout watchdog: routes CPU cycles to RAM or the I/O page,
// errors unmapped or unanswered cycles for one clock and records the faulting address.
module wbc_dec #(
  parameter logic [15:0] RAM_TOP  = 16'h4000,
  parameter logic [15:0] IO_BASE  = 16'hE000,
  parameter int          TIMEOUT  = 16,
  parameter int          TO_WIDTH = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] m_adr_i,
  input  logic [15:0] m_dat_i,
  output logic [15:0] m_dat_o,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [1:0]  m_sel_i,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic        ram_cyc_o,
  output logic        ram_stb_o,
  input  logic        ram_ack_i,
  input  logic [15:0] ram_dat_i,
  output logic        io_cyc_o,
  output logic        io_stb_o,
  input  logic        io_ack_i,
  input  logic [15:0] io_dat_i,
  output logic [15:0] err_adr_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR, DRAIN} state_t;

  state_t              state, state_next;
  logic [TO_WIDTH-1:0] cnt, cnt_next;
  logic                req, ram_hit, io_hit, unmapped, sel_ack, active;

  // Data, write-enable and byte selects go to the slaves on their own wiring, not through here.
  logic unused_fwd;
  assign unused_fwd = ^{m_dat_i, m_we_i, m_sel_i};

  assign req      = m_cyc_i & m_stb_i;
  assign ram_hit  = (m_adr_i < RAM_TOP);
  assign io_hit   = !ram_hit && (m_adr_i >= IO_BASE);
  assign unmapped = !ram_hit && !io_hit;
  assign sel_ack  = (ram_hit & ram_ack_i) | (io_hit & io_ack_i);
  assign active   = ((state == IDLE) || (state == BUSY)) && !wb_rst_i;

  assign ram_cyc_o = m_cyc_i & ram_hit;
  assign io_cyc_o  = m_cyc_i & io_hit;
  assign ram_stb_o = active & req & ram_hit;
  assign io_stb_o  = active & req & io_hit;
  assign m_ack_o   = active & req & sel_ack;
  assign m_err_o   = (state == ERR) && !wb_rst_i;

  always_comb begin
    m_dat_o = 16'h0000;
    if (ram_hit)
      m_dat_o = ram_dat_i;
    else if (io_hit)
      m_dat_o = io_dat_i;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req && !sel_ack) begin
          if (unmapped) begin
            state_next = ERR;
          end else begin
            state_next = BUSY;
            cnt_next   = TO_WIDTH'(1);
          end
        end
      end
      BUSY: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (!req || sel_ack) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == TO_WIDTH'(TIMEOUT - 1)) begin
          state_next = ERR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + TO_WIDTH'(1);
        end
      end
      ERR: begin
        cnt_next   = '0;
        state_next = req ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!req) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      err_adr_o <= 16'h0000;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == ERR) err_adr_o <= m_adr_i;
    end
  end

endmodule

// File: tb/tb_wbc_dec.sv
// Directed testbench for wbc_dec: decode, combinational/late acks, timeout, drain, abort and reset.
module tb_wbc_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m_adr, m_dat_w, m_dat_r, ram_dat, io_dat, err_adr;
  logic        m_cyc, m_stb, m_we, m_ack, m_err;
  logic [1:0]  m_sel;
  logic        ram_cyc, ram_stb, ram_ack, io_cyc, io_stb, io_ack;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wbc_dec dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat_w),
    .m_dat_o  (m_dat_r),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_sel_i  (m_sel),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .ram_cyc_o(ram_cyc),
    .ram_stb_o(ram_stb),
    .ram_ack_i(ram_ack),
    .ram_dat_i(ram_dat),
    .io_cyc_o (io_cyc),
    .io_stb_o (io_stb),
    .io_ack_i (io_ack),
    .io_dat_i (io_dat),
    .err_adr_o(err_adr)
  );

  task automatic bus_idle();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = 16'h0000;
    m_dat_w = 16'h0000; m_sel = 2'b00; ram_ack = 1'b0; io_ack = 1'b0;
  endtask

  task automatic bus_req(input logic [15:0] adr, input logic we);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_sel = 2'b11;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_req(16'h0100, 1'b0);
    ram_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if ({m_ack, m_err} !== 2'b00) $display("[TB] FAIL rst_ack_err: got %b expected 00", {m_ack, m_err}); else passed++;
    checks++; if ({ram_stb, io_stb} !== 2'b00) $display("[TB] FAIL rst_stb: got %b expected 00", {ram_stb, io_stb}); else passed++;
    checks++; if (err_adr !== 16'h0000) $display("[TB] FAIL rst_err_adr: got %h expected 0000", err_adr); else passed++;
    next_cycle();
    rst = 1'b0;
    bus_idle();
    next_cycle();
  endtask

  task automatic test_ram_write_read();
    bus_req(16'h0100, 1'b1);
    m_dat_w = 16'h1234;
    ram_ack = 1'b1;
    @(negedge clk);
    checks++; if ({ram_cyc, ram_stb, io_stb} !== 3'b110) $display("[TB] FAIL wr_stb: got %b expected 110", {ram_cyc, ram_stb, io_stb}); else passed++;
    checks++; if ({m_ack, m_err} !== 2'b10) $display("[TB] FAIL wr_ack: got %b expected 10", {m_ack, m_err}); else passed++;
    next_cycle();
    bus_idle();
    next_cycle();
    bus_req(16'h0100, 1'b0);
    ram_dat = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      ram_ack = (c == 2);
      @(negedge clk);
      checks++; if (ram_stb !== 1'b1) $display("[TB] FAIL rd_stb c%0d: got %b expected 1", c, ram_stb); else passed++;
      checks++; if (m_ack !== (c == 2)) $display("[TB] FAIL rd_ack c%0d: got %b expected %b", c, m_ack, (c == 2)); else passed++;
      next_cycle();
    end
    bus_req(16'h0100, 1'b0);
    ram_ack = 1'b1;
    @(negedge clk);
    checks++; if (m_dat_r !== 16'h1234) $display("[TB] FAIL rd_data: got %h expected 1234", m_dat_r); else passed++;
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_decode();
    ram_dat = 16'hAAAA;
    io_dat  = 16'h5555;
    bus_req(16'h3FFE, 1'b0);
    ram_ack = 1'b1;
    @(negedge clk);
    checks++; if ({ram_stb, io_stb, m_ack} !== 3'b101) $display("[TB] FAIL dec_3ffe: got %b expected 101", {ram_stb, io_stb, m_ack}); else passed++;
    next_cycle();
    bus_req(16'h4000, 1'b0);
    @(negedge clk);
    checks++; if ({ram_stb, io_stb, m_ack, m_err} !== 4'b0000) $display("[TB] FAIL dec_4000_c0: got %b expected 0000", {ram_stb, io_stb, m_ack, m_err}); else passed++;
    checks++; if (m_dat_r !== 16'h0000) $display("[TB] FAIL dec_unmapped_dat: got %h expected 0000", m_dat_r); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if ({ram_stb, io_stb, m_ack, m_err} !== 4'b0001) $display("[TB] FAIL dec_4000_c1: got %b expected 0001", {ram_stb, io_stb, m_ack, m_err}); else passed++;
    next_cycle();
    bus_idle();
    @(negedge clk);
    checks++; if (m_err !== 1'b0) $display("[TB] FAIL dec_err_once: got %b expected 0", m_err); else passed++;
    checks++; if (err_adr !== 16'h4000) $display("[TB] FAIL dec_err_adr: got %h expected 4000", err_adr); else passed++;
    next_cycle();
    bus_req(16'hE000, 1'b0);
    io_ack = 1'b1;
    @(negedge clk);
    checks++; if ({ram_stb, io_cyc, io_stb, m_ack} !== 4'b0111) $display("[TB] FAIL dec_e000: got %b expected 0111", {ram_stb, io_cyc, io_stb, m_ack}); else passed++;
    checks++; if (m_dat_r !== 16'h5555) $display("[TB] FAIL dec_io_dat: got %h expected 5555", m_dat_r); else passed++;
    next_cycle();
    bus_idle();
    next_cycle();
  endtask

  task automatic test_timeout();
    bus_req(16'hFF70, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++; if ({io_stb, m_err} !== 2'b10) $display("[TB] FAIL to_wait c%0d: got %b expected 10", c, {io_stb, m_err}); else passed++;
      next_cycle();
    end
    @(negedge clk);
    checks++; if ({io_stb, m_ack, m_err} !== 3'b001) $display("[TB] FAIL to_expire: got %b expected 001", {io_stb, m_ack, m_err}); else passed++;
    next_cycle();
    for (int c = 17; c < 20; c++) begin
      io_ack = (c == 18);
      @(negedge clk);
      checks++; if ({io_stb, m_ack, m_err} !== 3'b000) $display("[TB] FAIL to_drain c%0d: got %b expected 000", c, {io_stb, m_ack, m_err}); else passed++;
      next_cycle();
    end
    bus_idle();
    next_cycle();
    @(negedge clk);
    checks++; if (err_adr !== 16'hFF70) $display("[TB] FAIL to_err_adr: got %h expected ff70", err_adr); else passed++;
    next_cycle();
  endtask

  task automatic test_ack_at_expiry();
    bus_req(16'hFF70, 1'b0);
    for (int c = 0; c < 16; c++) begin
      io_ack = (c == 15);
      @(negedge clk);
      checks++; if ({m_ack, m_err} !== {(c == 15), 1'b0}) $display("[TB] FAIL exp_c%0d: got %b expected %b0", c, {m_ack, m_err}, (c == 15)); else passed++;
      next_cycle();
    end
    bus_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (m_err !== 1'b0) $display("[TB] FAIL exp_after c%0d: got %b expected 0", c, m_err); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_abort();
    bus_req(16'hFF70, 1'b0);
    repeat (5) next_cycle();
    m_stb = 1'b0;
    @(negedge clk);
    checks++; if ({io_stb, m_ack, m_err} !== 3'b000) $display("[TB] FAIL abort: got %b expected 000", {io_stb, m_ack, m_err}); else passed++;
    next_cycle();
    bus_req(16'h0200, 1'b0);
    ram_dat = 16'h5A5A;
    for (int c = 0; c < 16; c++) begin
      ram_ack = (c == 15);
      @(negedge clk);
      checks++; if ({m_ack, m_err} !== {(c == 15), 1'b0}) $display("[TB] FAIL abort_ram c%0d: got %b expected %b0", c, {m_ack, m_err}, (c == 15)); else passed++;
      next_cycle();
    end
    bus_idle();
    next_cycle();
  endtask

  task automatic test_reset_busy();
    bus_req(16'hFF70, 1'b0);
    repeat (8) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({m_ack, m_err, ram_stb, io_stb} !== 4'b0000) $display("[TB] FAIL rstb_outs: got %b expected 0000", {m_ack, m_err, ram_stb, io_stb}); else passed++;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (err_adr !== 16'h0000) $display("[TB] FAIL rstb_err_adr: got %h expected 0000", err_adr); else passed++;
      end
      checks++; if (m_err !== (c == 16)) $display("[TB] FAIL rstb_retime c%0d: got %b expected %b", c, m_err, (c == 16)); else passed++;
      next_cycle();
    end
    bus_idle();
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    ram_dat = 16'h1111;
    io_dat  = 16'h2222;
    bus_req(16'h0100, 1'b1);
    ram_ack = 1'b1;
    @(negedge clk);
    checks++; if ({ram_stb, m_ack} !== 2'b11) $display("[TB] FAIL b2b_ram: got %b expected 11", {ram_stb, m_ack}); else passed++;
    next_cycle();
    bus_req(16'hE000, 1'b1);
    ram_ack = 1'b0;
    io_ack  = 1'b1;
    @(negedge clk);
    checks++; if ({ram_stb, io_stb, m_ack} !== 3'b011) $display("[TB] FAIL b2b_io: got %b expected 011", {ram_stb, io_stb, m_ack}); else passed++;
    next_cycle();
    bus_req(16'hDFFF, 1'b0);
    @(negedge clk);
    checks++; if ({io_stb, m_ack, m_err} !== 3'b000) $display("[TB] FAIL b2b_unmapped: got %b expected 000", {io_stb, m_ack, m_err}); else passed++;
    checks++; if (m_dat_r !== 16'h0000) $display("[TB] FAIL b2b_dat: got %h expected 0000", m_dat_r); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if ({m_ack, m_err} !== 2'b01) $display("[TB] FAIL b2b_err: got %b expected 01", {m_ack, m_err}); else passed++;
    next_cycle();
    bus_idle();
    @(negedge clk);
    checks++; if (err_adr !== 16'hDFFF) $display("[TB] FAIL b2b_err_adr: got %h expected dfff", err_adr); else passed++;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    ram_dat = 16'h0000;
    io_dat  = 16'h0000;
    bus_idle();
    test_reset();
    test_ram_write_read();
    test_decode();
    test_timeout();
    test_ack_at_expiry();
    test_abort();
    test_reset_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
